mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
Multi-cycle MIPS control sequencer. It steps each instruction through FETCH/DECODE/EXE/MEM/WB states and drives every datapath select. That includes the immediate extender's ExtOp, the ALU, the register file, the PC/NPC unit and a shared instruction/data memory port with a ready handshake. It sits between the IR (Op/Funct), the ALU Zero flag and the memory, replacing the single-cycle combinational controller.

Parameters:
MEM_TIMEOUT, 255, max consecutive wait cycles (mem_req=1, mem_ready=0) before bus error; legal range 1..255.
TMR_W, 8, width of the wait counter; must satisfy 2^TMR_W > MEM_TIMEOUT.

Ports:
clk        in   1  single clock; all state updates on its rising edge
rst        in   1  asynchronous, active-low reset
Op         in   6  IR[31:26]; held stable by the IR after IRWrite
Funct      in   6  IR[5:0]
Zero       in   1  ALU zero flag
mem_ready  in   1  memory completes the current access this cycle
mem_req    out  1  memory access request
MemRead    out  1  read strobe
MemWrite   out  1  write strobe
IorD       out  1  0 = address from PC, 1 = address from ALUOut
IRWrite    out  1  load IR from memory data
PCWrite    out  1  load PC from NPC
NPCOp      out  2  `NPC_PLUS4 / `NPC_BRANCH / `NPC_JUMP / `NPC_JR
RegWrite   out  1  register-file write enable
RegDst     out  2  0 = rt, 1 = rd, 2 = $31
WDSel      out  2  0 = ALUOut, 1 = MDR, 2 = PC (link)
ALUSrcA    out  1  0 = rs, 1 = shamt
ALUSrcB    out  1  0 = rt, 1 = Imm32
ALUOp      out  4  `ALU_* code
ExtOp      out  2  `EXT_ZERO / `EXT_SIGNED / `EXT_HIGHPOS
bus_err    out  1  sticky memory-timeout flag
illegal    out  1  sticky illegal-opcode flag (constant 0 without macro)
state      out  4  current state, for debug

Behaviour:
- States: RESET, FETCH, DECODE, EXE, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, JUMP, ERR, TRAP.
- While rst=0: state=RESET, wait counter=0, bus_err=0, illegal=0.
- In RESET every control output is 0. It moves to FETCH on the first edge after reset releases.
- Control outputs are Moore functions of state, Op and Funct. The only exceptions are IRWrite and PCWrite in FETCH, which are also gated by mem_ready.
- Outputs not listed for a state are 0.
- FETCH: mem_req=MemRead=1, IorD=0, NPCOp=PLUS4. IRWrite=PCWrite=mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: always one cycle.
  - R-type (addu, subu, and, or, slt, sll) -> EXE
  - jr -> JUMP
  - ori, addi, lui -> EXE
  - lw, sw -> MEMADR
  - beq -> BRANCH
  - j, jal -> JUMP
  - anything else -> TRAP (with macro) or FETCH (without).
- EXE: ALUSrcA=1 only for sll; ALUSrcB=1 for I-type; ALUOp decoded from Op/Funct. Goes to ALUWB.
- ALUWB: RegWrite=1, WDSel=0, RegDst=1 for R-type else 0. Goes to FETCH.
- MEMADR: ALUSrcB=1, ALUOp=ADD. lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_req=MemRead=1, IorD=1. Goes to MEMWB on mem_ready.
- MEMWR: mem_req=MemWrite=1, IorD=1. Goes to FETCH on mem_ready.
- MEMWB: RegWrite=1, WDSel=1, RegDst=0. Goes to FETCH.
- BRANCH: ALUOp=SUB, NPCOp=BRANCH, PCWrite=Zero. Goes to FETCH.
- JUMP:
  - j: PCWrite=1, NPCOp=JUMP.
  - jal: PCWrite=1, NPCOp=JUMP, plus RegWrite=1, RegDst=2, WDSel=2 in the same cycle (PC is written at the edge, so link uses pre-update PC+4).
  - jr: PCWrite=1, NPCOp=JR.
  - Goes to FETCH.
- ExtOp is decoded from Op in every state from DECODE onward:
  - ori -> `EXT_ZERO
  - lui -> `EXT_HIGHPOS
  - addi, lw, sw, beq -> `EXT_SIGNED
  - all others -> `EXT_ZERO
- Cycle counts with zero-wait memory: R/I-type 4, lw 5, sw 4, beq 3, j/jal/jr 3.
- Wait counter:
  - Increments in each memory state cycle with mem_ready=0.
  - Clears whenever mem_ready=1 or the state is not a memory state.
  - When the counter equals MEM_TIMEOUT with mem_ready still 0, the next state is ERR.
  - mem_ready=1 in the same cycle as the timeout wins; the normal transition is taken.
- ERR: all outputs 0, bus_err=1, held until reset.
- TRAP: all outputs 0, illegal=1, held until reset.
- Reset asserted mid-instruction aborts immediately, with no partial write.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: unknown opcodes and unknown R-type functs go DECODE -> TRAP, which sets illegal and holds until reset.
- Undefined: they are executed as a NOP (DECODE -> FETCH, no writes), illegal is tied to 0, and the TRAP state is unreachable.

Decomposition:
- State encodings, `EXT_ZERO=2'b00 / `EXT_SIGNED=2'b01 / `EXT_HIGHPOS=2'b10, `NPC_*, `ALU_*, and the opcode/funct constants all live in the shared ctrl_encode_def.v header.
- One natural sub-module, mc_alu_dec: combinational Op/Funct -> ALUOp, ExtOp, ALUSrcA/B.
- The FSM, wait counter and sticky flags stay in mc_ctrl.

Test Plan:
- addu $3,$1,$2 (Op=0, Funct=0x21), mem_ready=1 -> states FETCH, DECODE, EXE, ALUWB; RegWrite=1 and RegDst=1 in cycle 4; PCWrite=1 only in cycle 1.
- lui (Op=0x0F) then ori (Op=0x0D) -> ExtOp=2'b10 during lui, 2'b00 during ori; lw with mem_ready low 3 cycles in MEMRD -> total 8 cycles, MEMWB RegWrite=1, WDSel=1.
- beq (Op=0x04): Zero=1 -> PCWrite=1, NPCOp=BRANCH in cycle 3; Zero=0 -> PCWrite=0; ExtOp=2'b01 both cases.
- jal (Op=0x03) -> JUMP cycle has PCWrite=1, RegWrite=1, RegDst=2, WDSel=2 simultaneously.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> ERR after 5 wait cycles, bus_err=1 until rst pulsed low.
- Op=0x3F with ILLEGAL_TRAP_EN -> TRAP, illegal=1; without the macro -> back to FETCH, no writes; rst low mid-MEMWR -> MemWrite drops immediately, state=RESET.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle MIPS control sequencer.
// Holds the FSM state encoding, the instruction class used for dispatch,
// opcode/funct constants, and the ALUOp / NPCOp / ExtOp code points that the
// datapath decodes. classify() maps an IR Op/Funct pair to its class.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXE    = 4'd3,
        S_ALUWB  = 4'd4,
        S_MEMADR = 4'd5,
        S_MEMRD  = 4'd6,
        S_MEMWB  = 4'd7,
        S_MEMWR  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ERR    = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    typedef enum logic [3:0] {
        IC_RALU = 4'd0,
        IC_IALU = 4'd1,
        IC_LW   = 4'd2,
        IC_SW   = 4'd3,
        IC_BEQ  = 4'd4,
        IC_J    = 4'd5,
        IC_JAL  = 4'd6,
        IC_JR   = 4'd7,
        IC_BAD  = 4'd8
    } iclass_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type functs (IR[5:0])
    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;

    // ALU operation codes
    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_LUI = 4'd7;

    // Next-PC source select
    localparam logic [1:0] NPC_PLUS4  = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_JR     = 2'd3;

    // Immediate extender mode
    localparam logic [1:0] EXT_ZERO    = 2'b00;
    localparam logic [1:0] EXT_SIGNED  = 2'b01;
    localparam logic [1:0] EXT_HIGHPOS = 2'b10;

    // Map an IR Op/Funct pair onto the dispatch class used by DECODE.
    function automatic iclass_t classify(input logic [5:0] op, input logic [5:0] funct);
        iclass_t c;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FUNCT_ADDU, FUNCT_SUBU, FUNCT_AND,
                    FUNCT_OR, FUNCT_SLT, FUNCT_SLL: c = IC_RALU;
                    FUNCT_JR:                       c = IC_JR;
                    default:                        c = IC_BAD;
                endcase
            end
            OP_ORI, OP_ADDI, OP_LUI: c = IC_IALU;
            OP_LW:                   c = IC_LW;
            OP_SW:                   c = IC_SW;
            OP_BEQ:                  c = IC_BEQ;
            OP_J:                    c = IC_J;
            OP_JAL:                  c = IC_JAL;
            default:                 c = IC_BAD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: combinational Op/Funct decode for the execute-side selects.
// Ports:
//   op, funct  : IR opcode and funct fields
//   alu_op     : ALU operation for the EXE cycle of R/I-type ALU instructions
//   ext_op     : immediate extender mode (depends on op only)
//   alu_src_a  : 1 selects shamt as ALU A operand (sll only)
//   alu_src_b  : 1 selects Imm32 as ALU B operand (I-type ALU instructions)
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic [1:0] ext_op,
    output logic       alu_src_a,
    output logic       alu_src_b
);

    // ALU operation and operand selects from Op/Funct
    always_comb begin
        alu_op    = ALU_NOP;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FUNCT_ADDU: alu_op = ALU_ADD;
                    FUNCT_SUBU: alu_op = ALU_SUB;
                    FUNCT_AND:  alu_op = ALU_AND;
                    FUNCT_OR:   alu_op = ALU_OR;
                    FUNCT_SLT:  alu_op = ALU_SLT;
                    FUNCT_SLL: begin
                        alu_op    = ALU_SLL;
                        alu_src_a = 1'b1;
                    end
                    default:    alu_op = ALU_NOP;
                endcase
            end
            OP_ORI: begin
                alu_op    = ALU_OR;
                alu_src_b = 1'b1;
            end
            OP_ADDI: begin
                alu_op    = ALU_ADD;
                alu_src_b = 1'b1;
            end
            OP_LUI: begin
                alu_op    = ALU_LUI;
                alu_src_b = 1'b1;
            end
            default: alu_op = ALU_NOP;
        endcase
    end

    // Immediate extension mode from the opcode alone
    always_comb begin
        case (op)
            OP_ORI:                        ext_op = EXT_ZERO;
            OP_LUI:                        ext_op = EXT_HIGHPOS;
            OP_ADDI, OP_LW, OP_SW, OP_BEQ: ext_op = EXT_SIGNED;
            default:                       ext_op = EXT_ZERO;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control sequencer.
// Steps each instruction through FETCH/DECODE/EXE/MEM/WB and drives all
// datapath selects as Moore functions of state/Op/Funct (IRWrite/PCWrite in
// FETCH are additionally gated by mem_ready). A wait counter turns a memory
// access stalled for more than MEM_TIMEOUT cycles into a sticky bus error.
// Optional build macro ILLEGAL_TRAP_EN: unknown instructions enter TRAP and
// set the sticky illegal flag; without it they retire as NOPs.
// Ports:
//   clk, rst (async active-low), Op/Funct (IR fields), Zero (ALU flag),
//   mem_ready (memory handshake); outputs mem_req, MemRead, MemWrite, IorD,
//   IRWrite, PCWrite, NPCOp, RegWrite, RegDst, WDSel, ALUSrcA, ALUSrcB,
//   ALUOp, ExtOp, bus_err, illegal, state (debug view of the FSM).
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TMR_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] NPCOp,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] WDSel,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [3:0] ALUOp,
    output logic [1:0] ExtOp,
    output logic       bus_err,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [TMR_W-1:0] TMO_CNT = TMR_W'(MEM_TIMEOUT);

    state_t           state_r;
    logic [TMR_W-1:0] wait_cnt_r;
    logic             bus_err_r;
    iclass_t          iclass_s;
    logic             mem_state_s;
    logic             timeout_s;
    logic [3:0]       dec_alu_op_s;
    logic [1:0]       dec_ext_s;
    logic             dec_src_a_s;
    logic             dec_src_b_s;

    mc_alu_dec u_alu_dec (
        .op        (Op),
        .funct     (Funct),
        .alu_op    (dec_alu_op_s),
        .ext_op    (dec_ext_s),
        .alu_src_a (dec_src_a_s),
        .alu_src_b (dec_src_b_s)
    );

    assign iclass_s    = classify(Op, Funct);
    assign mem_state_s = (state_r == S_FETCH) || (state_r == S_MEMRD) || (state_r == S_MEMWR);
    // A ready in the timeout cycle still completes the access normally.
    assign timeout_s   = mem_state_s && !mem_ready && (wait_cnt_r == TMO_CNT);

    // Instruction sequencing FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_RESET;
        end else begin
            case (state_r)
                S_RESET:  state_r <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready)      state_r <= S_DECODE;
                    else if (timeout_s) state_r <= S_ERR;
                    else                state_r <= S_FETCH;
                end
                S_DECODE: begin
                    case (iclass_s)
                        IC_RALU, IC_IALU:   state_r <= S_EXE;
                        IC_LW, IC_SW:       state_r <= S_MEMADR;
                        IC_BEQ:             state_r <= S_BRANCH;
                        IC_J, IC_JAL, IC_JR: state_r <= S_JUMP;
`ifdef ILLEGAL_TRAP_EN
                        default:            state_r <= S_TRAP;
`else
                        default:            state_r <= S_FETCH;
`endif
                    endcase
                end
                S_EXE:    state_r <= S_ALUWB;
                S_ALUWB:  state_r <= S_FETCH;
                S_MEMADR: state_r <= (iclass_s == IC_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD: begin
                    if (mem_ready)      state_r <= S_MEMWB;
                    else if (timeout_s) state_r <= S_ERR;
                    else                state_r <= S_MEMRD;
                end
                S_MEMWR: begin
                    if (mem_ready)      state_r <= S_FETCH;
                    else if (timeout_s) state_r <= S_ERR;
                    else                state_r <= S_MEMWR;
                end
                S_MEMWB:  state_r <= S_FETCH;
                S_BRANCH: state_r <= S_FETCH;
                S_JUMP:   state_r <= S_FETCH;
                S_ERR:    state_r <= S_ERR;
                S_TRAP:   state_r <= S_TRAP;
                default:  state_r <= S_RESET;
            endcase
        end
    end

    // Consecutive memory wait-cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_r <= '0;
        end else if (mem_state_s && !mem_ready) begin
            wait_cnt_r <= wait_cnt_r + TMR_W'(1);
        end else begin
            wait_cnt_r <= '0;
        end
    end

    // Sticky bus-error flag, set on the edge that enters ERR
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_err_r <= 1'b0;
        end else begin
            bus_err_r <= bus_err_r | timeout_s;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_r;

    // Sticky illegal-instruction flag, set on the edge that enters TRAP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_r <= 1'b0;
        end else begin
            illegal_r <= illegal_r | ((state_r == S_DECODE) && (iclass_s == IC_BAD));
        end
    end

    assign illegal = illegal_r;
`else
    assign illegal = 1'b0;
`endif

    assign bus_err = bus_err_r;
    assign state   = state_r;

    // Moore decode of datapath controls from the current state
    always_comb begin
        mem_req  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        NPCOp    = NPC_PLUS4;
        RegWrite = 1'b0;
        RegDst   = 2'd0;
        WDSel    = 2'd0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 1'b0;
        ALUOp    = ALU_NOP;
        ExtOp    = EXT_ZERO;
        case (state_r)
            S_FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: ExtOp = dec_ext_s;
            S_EXE: begin
                ALUSrcA = dec_src_a_s;
                ALUSrcB = dec_src_b_s;
                ALUOp   = dec_alu_op_s;
                ExtOp   = dec_ext_s;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = (iclass_s == IC_RALU) ? 2'd1 : 2'd0;
                ExtOp    = dec_ext_s;
            end
            S_MEMADR: begin
                ALUSrcB = 1'b1;
                ALUOp   = ALU_ADD;
                ExtOp   = dec_ext_s;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                IorD    = 1'b1;
                ExtOp   = dec_ext_s;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                WDSel    = 2'd1;
                ExtOp    = dec_ext_s;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                IorD     = 1'b1;
                ExtOp    = dec_ext_s;
            end
            S_BRANCH: begin
                ALUOp   = ALU_SUB;
                NPCOp   = NPC_BRANCH;
                PCWrite = Zero;
                ExtOp   = dec_ext_s;
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                ExtOp   = dec_ext_s;
                case (iclass_s)
                    IC_JR:   NPCOp = NPC_JR;
                    IC_JAL: begin
                        // Link is written with the pre-update PC (PC+4) on the same edge.
                        NPCOp    = NPC_JUMP;
                        RegWrite = 1'b1;
                        RegDst   = 2'd2;
                        WDSel    = 2'd2;
                    end
                    default: NPCOp = NPC_JUMP;
                endcase
            end
            default: ExtOp = EXT_ZERO;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized self-checking bench for mc_ctrl. Each instruction
// is expanded from its mnemonic into an expected per-cycle trace (state plus
// every control output), with random memory wait counts, and the DUT is
// compared cycle by cycle. Directed cases cover timeout, reset and NOP/trap.
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    localparam int TMO = 4;

    typedef enum int {I_ADDU, I_SUBU, I_AND, I_OR, I_SLT, I_SLL, I_JR, I_ORI,
                      I_ADDI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_BAD} mn_t;

    typedef struct packed {
        logic       mem_req, mem_rd, mem_wr, iord, irw, pcw;
        logic [1:0] npc;
        logic       rw;
        logic [1:0] rdst, wds;
        logic       sa, sb;
        logic [3:0] aluop;
        logic [1:0] ext;
        logic       berr, ill;
    } ctl_t;

    typedef struct packed {
        state_t st;
        ctl_t   ctl;
        logic   rdy;
    } exp_t;

    logic       clk, rst, Zero, mem_ready;
    logic [5:0] Op, Funct;
    logic       mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite;
    logic [1:0] NPCOp, RegDst, WDSel, ExtOp;
    logic       RegWrite, ALUSrcA, ALUSrcB, bus_err, illegal;
    logic [3:0] ALUOp, state;
    ctl_t       obs;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t tq[$];

    mc_ctrl #(.MEM_TIMEOUT(TMO), .TMR_W(8)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .MemRead(MemRead),
        .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .NPCOp(NPCOp), .RegWrite(RegWrite), .RegDst(RegDst), .WDSel(WDSel),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtOp(ExtOp),
        .bus_err(bus_err), .illegal(illegal), .state(state)
    );

    assign obs = {mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, NPCOp,
                  RegWrite, RegDst, WDSel, ALUSrcA, ALUSrcB, ALUOp, ExtOp,
                  bus_err, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Opcode/funct encoding of each mnemonic (funct is don't-care for non R-type).
    task automatic encode(input mn_t m, output logic [5:0] op, output logic [5:0] fn);
        fn = 6'($urandom);
        op = 6'h00;
        case (m)
            I_ADDU: fn = 6'h21;
            I_SUBU: fn = 6'h23;
            I_AND:  fn = 6'h24;
            I_OR:   fn = 6'h25;
            I_SLT:  fn = 6'h2A;
            I_SLL:  fn = 6'h00;
            I_JR:   fn = 6'h08;
            I_ORI:  op = 6'h0D;
            I_ADDI: op = 6'h08;
            I_LUI:  op = 6'h0F;
            I_LW:   op = 6'h23;
            I_SW:   op = 6'h2B;
            I_BEQ:  op = 6'h04;
            I_J:    op = 6'h02;
            I_JAL:  op = 6'h03;
            default: begin
                if ($urandom_range(0, 1) == 0) op = 6'h3F;
                else fn = 6'h3F;
            end
        endcase
    endtask

    function automatic logic [3:0] alu_of(input mn_t m);
        case (m)
            I_ADDU, I_ADDI: return ALU_ADD;
            I_SUBU:         return ALU_SUB;
            I_AND:          return ALU_AND;
            I_OR, I_ORI:    return ALU_OR;
            I_SLT:          return ALU_SLT;
            I_SLL:          return ALU_SLL;
            I_LUI:          return ALU_LUI;
            default:        return ALU_NOP;
        endcase
    endfunction

    function automatic logic [1:0] ext_of(input mn_t m);
        case (m)
            I_LUI:                      return EXT_HIGHPOS;
            I_ADDI, I_LW, I_SW, I_BEQ:  return EXT_SIGNED;
            default:                    return EXT_ZERO;
        endcase
    endfunction

    task automatic push_e(input state_t s, input ctl_t c, input logic r);
        exp_t e;
        e.st = s; e.ctl = c; e.rdy = r;
        tq.push_back(e);
    endtask

    // Expected cycle trace of one instruction: wf fetch waits, wm data waits.
    task automatic build(input mn_t m, input logic z, input int wf, input int wm);
        ctl_t       c;
        logic [1:0] x;
        logic       is_r, is_i;
        x    = ext_of(m);
        is_r = (m inside {I_ADDU, I_SUBU, I_AND, I_OR, I_SLT, I_SLL});
        is_i = (m inside {I_ORI, I_ADDI, I_LUI});
        for (int i = 0; i <= wf; i++) begin
            c = '0; c.mem_req = 1'b1; c.mem_rd = 1'b1; c.npc = NPC_PLUS4;
            c.irw = (i == wf); c.pcw = (i == wf);
            push_e(S_FETCH, c, i == wf);
        end
        c = '0; c.ext = x; push_e(S_DECODE, c, 1'($urandom));
        if (is_r || is_i) begin
            c = '0; c.ext = x; c.aluop = alu_of(m); c.sa = (m == I_SLL); c.sb = is_i;
            push_e(S_EXE, c, 1'($urandom));
            c = '0; c.ext = x; c.rw = 1'b1; c.rdst = is_r ? 2'd1 : 2'd0;
            push_e(S_ALUWB, c, 1'($urandom));
        end else if (m == I_LW || m == I_SW) begin
            c = '0; c.ext = x; c.sb = 1'b1; c.aluop = ALU_ADD;
            push_e(S_MEMADR, c, 1'($urandom));
            for (int i = 0; i <= wm; i++) begin
                c = '0; c.ext = x; c.mem_req = 1'b1; c.iord = 1'b1;
                c.mem_rd = (m == I_LW); c.mem_wr = (m == I_SW);
                push_e((m == I_LW) ? S_MEMRD : S_MEMWR, c, i == wm);
            end
            if (m == I_LW) begin
                c = '0; c.ext = x; c.rw = 1'b1; c.wds = 2'd1;
                push_e(S_MEMWB, c, 1'($urandom));
            end
        end else if (m == I_BEQ) begin
            c = '0; c.ext = x; c.aluop = ALU_SUB; c.npc = NPC_BRANCH; c.pcw = z;
            push_e(S_BRANCH, c, 1'($urandom));
        end else if (m == I_J || m == I_JAL || m == I_JR) begin
            c = '0; c.ext = x; c.pcw = 1'b1;
            c.npc = (m == I_JR) ? NPC_JR : NPC_JUMP;
            if (m == I_JAL) begin
                c.rw = 1'b1; c.rdst = 2'd2; c.wds = 2'd2;
            end
            push_e(S_JUMP, c, 1'($urandom));
        end else begin
`ifdef ILLEGAL_TRAP_EN
            c = '0; c.ill = 1'b1;
            for (int i = 0; i < 3; i++) push_e(S_TRAP, c, 1'($urandom));
`endif
        end
    endtask

    // Play the expected trace against the DUT; called at posedge+1.
    task automatic run_trace(input mn_t m, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int limit);
        exp_t e;
        int   n = 0;
        while (tq.size() > 0 && (limit < 0 || n < limit)) begin
            e         = tq.pop_front();
            Op        = (e.st == S_FETCH) ? 6'($urandom) : op;
            Funct     = (e.st == S_FETCH) ? 6'($urandom) : fn;
            Zero      = (e.st == S_BRANCH) ? z : 1'($urandom);
            mem_ready = e.rdy;
            #4;
            check($sformatf("%s_state", m.name()), 32'(state), 32'(e.st));
            check($sformatf("%s_ctl", m.name()), 32'(obs), 32'(e.ctl));
            @(posedge clk); #1;
            n++;
        end
        tq.delete();
    endtask

    task automatic do_instr(input mn_t m, input logic z, input int wf, input int wm);
        logic [5:0] op, fn;
        encode(m, op, fn);
        build(m, z, wf, wm);
        run_trace(m, op, fn, z, -1);
    endtask

    // Pulse reset at posedge+1 and check the reset state and restart.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        #2;
        check({tag, "_rst_state"}, 32'(state), 32'(S_RESET));
        check({tag, "_rst_ctl"}, 32'(obs), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check({tag, "_restart"}, 32'(state), 32'(S_FETCH));
    endtask

    initial begin
        ctl_t       c;
        logic [5:0] op, fn;
        mn_t        m;
        rst = 1'b0; Op = 6'h00; Funct = 6'h00; Zero = 1'b1; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(state), 32'(S_RESET));
        check("reset_ctl", 32'(obs), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("first_fetch", 32'(state), 32'(S_FETCH));

        // Directed instructions
        do_instr(I_ADDU, 1'b0, 0, 0);
        do_instr(I_LUI,  1'b0, 0, 0);
        do_instr(I_ORI,  1'b0, 0, 0);
        do_instr(I_LW,   1'b0, 0, 3);
        do_instr(I_BEQ,  1'b1, 0, 0);
        do_instr(I_BEQ,  1'b0, 0, 0);
        do_instr(I_JAL,  1'b0, 0, 0);
        do_instr(I_SW,   1'b0, 1, TMO);
        do_instr(I_LW,   1'b0, TMO, TMO);
        do_instr(I_BAD,  1'b0, 0, 0);
`ifdef ILLEGAL_TRAP_EN
        do_reset("trap");
`endif

        // Random instruction stream
        for (int k = 0; k < 60; k++) begin
`ifdef ILLEGAL_TRAP_EN
            m = mn_t'($urandom_range(0, 14));
`else
            m = mn_t'($urandom_range(0, 15));
`endif
            do_instr(m, 1'($urandom), $urandom_range(0, TMO), $urandom_range(0, TMO));
        end

        // Fetch timeout -> ERR, sticky until reset
        for (int i = 0; i <= TMO; i++) begin
            mem_ready = 1'b0; Op = 6'($urandom);
            #4;
            check("tmo_wait_state", 32'(state), 32'(S_FETCH));
            check("tmo_wait_berr", 32'(bus_err), 32'd0);
            @(posedge clk); #1;
        end
        c = '0; c.berr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'($urandom);
            #4;
            check("tmo_err_state", 32'(state), 32'(S_ERR));
            check("tmo_err_ctl", 32'(obs), 32'(c));
            @(posedge clk); #1;
        end
        do_reset("tmo");

        // Reset asserted while a store waits in MEMWR
        encode(I_SW, op, fn);
        build(I_SW, 1'b0, 0, 2);
        run_trace(I_SW, op, fn, 1'b0, 4);
        mem_ready = 1'b0;
        #2;
        check("memwr_pre_rst", 32'(MemWrite), 32'd1);
        rst = 1'b0;
        #1;
        check("memwr_abort_we", 32'(MemWrite), 32'd0);
        check("memwr_abort_state", 32'(state), 32'(S_RESET));
        check("memwr_abort_ctl", 32'(obs), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("memwr_restart", 32'(state), 32'(S_FETCH));
        do_instr(I_ADDI, 1'b0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
